// File: rtl/input_conditioner.sv
// Game front end: synchronizes and debounces the fire button and select switches,
// latches a one-hot row/column target and qualifies fire presses into strobes.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire_btn,
    input  logic [3:0] sw_raw,
    input  logic       n_row_raw,
    output logic [3:0] row,
    output logic [3:0] column,
    output logic       target_valid,
    output logic       sel_error,
    output logic       fire_pulse,
    output logic       fire_reject,
    output logic [7:0] shots
);

    localparam int N = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bit map: [3:0] switches, [4] fire, [5] row/column mode
    logic [N-1:0]     raw_p0;
    logic [N-1:0]     sync_p0, sync_p1;
    logic [N-1:0]     stable_p2;
    logic [CNT_W-1:0] cnt_p2 [N];

    assign raw_p0 = {n_row_raw, fire_btn, sw_raw};

    // Stage 0/1: two-flop synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw_p0;
            sync_p1 <= sync_p0;
        end
    end

    // Stage 2: per-input debounce; any return to the stable level restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_p2 <= '0;
            for (int i = 0; i < N; i++) cnt_p2[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync_p1[i] == stable_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    stable_p2[i] <= sync_p1[i];
                    cnt_p2[i]    <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    logic [3:0] sw_s;
    logic       fire_s, n_row_s;
    logic [2:0] sw_pop;
    logic       one_hot, multi_hot;
    logic       fire_prev_p3, fire_rise;
    logic       row_ok, col_ok;

    assign sw_s      = stable_p2[3:0];
    assign fire_s    = stable_p2[4];
    assign n_row_s   = stable_p2[5];
    assign sw_pop    = popcount4(sw_s);
    assign one_hot   = (sw_pop == 3'd1);
    assign multi_hot = (sw_pop >= 3'd2);
    assign fire_rise = fire_s & ~fire_prev_p3;

    assign target_valid = row_ok & col_ok;

    // Stage 3: target latch and fire qualification against this cycle's registered target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row          <= '0;
            column       <= '0;
            row_ok       <= 1'b0;
            col_ok       <= 1'b0;
            sel_error    <= 1'b0;
            fire_prev_p3 <= 1'b0;
            fire_pulse   <= 1'b0;
            fire_reject  <= 1'b0;
            shots        <= '0;
        end else begin
            sel_error    <= multi_hot;
            fire_prev_p3 <= fire_s;
            fire_pulse   <= 1'b0;
            fire_reject  <= 1'b0;
            if (one_hot) begin
                if (!n_row_s) begin
                    row    <= sw_s;
                    row_ok <= 1'b1;
                end else begin
                    column <= sw_s;
                    col_ok <= 1'b1;
                end
            end
            if (fire_rise) begin
                if (target_valid && !sel_error) begin
                    fire_pulse <= 1'b1;
                    shots      <= sat_inc(shots);
                end else begin
                    fire_reject <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a four-cycle debounce window.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       fire_btn;
    logic [3:0] sw_raw;
    logic       n_row_raw;
    logic [3:0] row, column;
    logic       target_valid, sel_error, fire_pulse, fire_reject;
    logic [7:0] shots;

    input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .fire_btn(fire_btn), .sw_raw(sw_raw),
        .n_row_raw(n_row_raw), .row(row), .column(column),
        .target_valid(target_valid), .sel_error(sel_error),
        .fire_pulse(fire_pulse), .fire_reject(fire_reject), .shots(shots)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    int n_pulse = 0;
    int n_rej = 0;
    logic prev_strobe = 1'b0;

    // Strobe tally plus exclusivity / no-back-to-back watch
    always @(negedge clk) begin
        if (fire_pulse) n_pulse++;
        if (fire_reject) n_rej++;
        if (fire_pulse && fire_reject) begin
            n_miss++;
            $display("FAIL strobe_excl: pulse=%0b reject=%0b required not both", fire_pulse, fire_reject);
        end
        if (prev_strobe && (fire_pulse || fire_reject)) begin
            n_miss++;
            $display("FAIL strobe_gap: strobe in consecutive cycles, required separation");
        end
        prev_strobe = fire_pulse | fire_reject;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic f, input logic [3:0] s, input logic nr);
        fire_btn  = f;
        sw_raw    = s;
        n_row_raw = nr;
        repeat (12) step();
    endtask

    task automatic press();
        fire_btn = 1'b1;
        repeat (8) step();
        fire_btn = 1'b0;
        repeat (8) step();
    endtask

    typedef struct {
        logic       fire;
        logic [3:0] sw;
        logic       n_row;
        logic [3:0] row;
        logic [3:0] col;
        logic       tv;
        logic       err;
        logic [7:0] shots;
        int         pulses;
        int         rejects;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    initial begin
        int p0, r0, lat;
        bit found;

        vt[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0, 0, 0};
        vt[1]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd0, 0, 0};
        vt[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd0, 0, 0};
        vt[3]  = '{1'b1, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd0, 0, 1};
        vt[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd0, 0, 1};
        vt[5]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd0, 0, 1};
        vt[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b0, 8'd0, 0, 1};
        vt[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b0, 8'd0, 0, 1};
        vt[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b0, 8'd1, 1, 1};
        vt[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b0, 8'd1, 1, 1};
        vt[10] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b1, 8'd1, 1, 1};
        vt[11] = '{1'b1, 4'b0110, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b1, 8'd1, 1, 2};
        vt[12] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b1, 8'd1, 1, 2};
        vt[13] = '{1'b0, 4'b0000, 1'b1, 4'b0010, 4'b0100, 1'b1, 1'b0, 8'd1, 1, 2};
        vt[14] = '{1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0100, 1'b1, 1'b0, 8'd1, 1, 2};
        vt[15] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd1, 1, 2};
        vt[16] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd1, 1, 2};
        vt[17] = '{1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd1, 1, 2};
        vt[18] = '{1'b0, 4'b0001, 1'b1, 4'b0100, 4'b0001, 1'b1, 1'b0, 8'd1, 1, 2};
        vt[19] = '{1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0001, 1'b1, 1'b0, 8'd1, 1, 2};
        vt[20] = '{1'b1, 4'b0000, 1'b1, 4'b0100, 4'b0001, 1'b1, 1'b0, 8'd2, 2, 2};
        vt[21] = '{1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0001, 1'b1, 1'b0, 8'd2, 2, 2};

        // Reset held with random raw inputs
        reset = 1'b0;
        fire_btn = 1'b0; sw_raw = 4'b0000; n_row_raw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            fire_btn  = 1'($urandom_range(0, 1));
            sw_raw    = 4'($urandom_range(0, 15));
            n_row_raw = 1'($urandom_range(0, 1));
            step();
            check($sformatf("reset_hold%0d", c),
                  {14'd0, row, column, target_valid, sel_error, fire_pulse, fire_reject, shots}, 32'd0);
        end
        fire_btn = 1'b0; sw_raw = 4'b0000; n_row_raw = 1'b0;
        step();
        reset = 1'b1;
        repeat (10) step();
        check("reset_release",
              {14'd0, row, column, target_valid, sel_error, fire_pulse, fire_reject, shots}, 32'd0);

        // Selection, error and fire-qualification table
        for (int i = 0; i < NV; i++) begin
            apply(vt[i].fire, vt[i].sw, vt[i].n_row);
            check($sformatf("vec%0d_out", i),
                  {14'd0, row, column, target_valid, sel_error, shots},
                  {14'd0, vt[i].row, vt[i].col, vt[i].tv, vt[i].err, vt[i].shots});
            check($sformatf("vec%0d_strobes", i), {n_pulse[15:0], n_rej[15:0]},
                  {vt[i].pulses[15:0], vt[i].rejects[15:0]});
        end

        // Bounce rejection with row=0010, column=0100
        apply(1'b0, 4'b0010, 1'b0);
        apply(1'b0, 4'b0000, 1'b0);
        apply(1'b0, 4'b0000, 1'b1);
        apply(1'b0, 4'b0100, 1'b1);
        apply(1'b0, 4'b0000, 1'b1);
        check("bounce_target", {24'd0, row, column}, {24'd0, 4'b0010, 4'b0100});
        p0 = n_pulse; r0 = n_rej;
        for (int k = 0; k < 5; k++) begin
            fire_btn = 1'b1; repeat (2) step();
            fire_btn = 1'b0; repeat (2) step();
        end
        fire_btn = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (fire_pulse) begin
                lat = c;
                break;
            end
        end
        check("bounce_latency", lat, 7);
        repeat (10) step();
        check("bounce_pulses", n_pulse - p0, 1);
        check("bounce_rejects", n_rej - r0, 0);
        check("bounce_shots", {24'd0, shots}, 32'd3);
        fire_btn = 1'b0;
        repeat (12) step();

        // Saturation of the shot counter
        p0 = n_pulse;
        repeat (260) press();
        check("sat_shots", {24'd0, shots}, 32'd255);
        check("sat_pulses", n_pulse - p0, 260);

        // Reset asserted in the pulse cycle clears everything at once
        fire_btn = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (fire_pulse) begin
                found = 1'b1;
                break;
            end
        end
        check("pulse_seen_before_reset", {31'd0, found}, 32'd1);
        p0 = n_pulse; r0 = n_rej;
        reset = 1'b0;
        #1;
        check("reset_in_pulse",
              {14'd0, row, column, target_valid, sel_error, fire_pulse, fire_reject, shots}, 32'd0);

        // Button held through reset release yields a reject
        repeat (3) step();
        reset = 1'b1;
        repeat (12) step();
        check("held_reset_rejects", n_rej - r0, 1);
        check("held_reset_pulses", n_pulse - p0, 0);
        check("held_reset_shots", {24'd0, shots}, 32'd0);
        fire_btn = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end input stage for the game top level. It takes the raw fire button, the four row/column select switches and the row/column mode switch, and synchronizes and debounces each one. It then validates the select switches as one-hot and latches the selected row and column. It emits a single-cycle fire strobe that the cell array consumes together with the latched one-hot row/column enables.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000 — consecutive stable cycles needed to accept a new input level (10 ms at 100 MHz); must be ≥2.
- CNT_W, 20 — debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- fire_btn  input  1  raw fire pushbutton, asynchronous, bouncy.
- sw_raw  input  4  raw row/column select switches, asynchronous, bouncy.
- n_row_raw  input  1  raw mode switch: 0 selects row, 1 selects column.
- row  output  4  latched one-hot row enable.
- column  output  4  latched one-hot column enable.
- target_valid  output  1  both a row and a column have been latched since reset.
- sel_error  output  1  debounced switches have two or more bits set.
- fire_pulse  output  1  one-cycle accepted-fire strobe.
- fire_reject  output  1  one-cycle strobe: fire was pressed without a valid target, or while sel_error was set.
- shots  output  8  count of accepted fires, saturating at 255.

## Operation
- Synchronization: each of the 6 raw inputs passes through a 2-flop synchronizer.
- Debounce: each input has a CNT_W-bit counter and a `stable` register.
  - If the synced value equals `stable`, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1, `stable` takes the synced value on that edge and the counter clears.
  - A single-cycle return to the old level restarts the count.
- Switch classification, on the debounced switches sw_s:
  - Exactly one bit set: valid selection.
  - Zero bits set: idle. No update, sel_error=0.
  - Two or more bits set: sel_error=1 (registered). No update.
- Latch: on a valid selection, sw_s loads into `row` if the debounced n_row is 0, otherwise into `column`.
  - The matching row_ok or col_ok flag is set.
  - Latching is level-based: it repeats every cycle while the selection is valid.
  - target_valid = row_ok & col_ok.
- Fire: fire_rise = debounced fire is 1 and its previous value was 0.
  - On fire_rise with target_valid=1 and sel_error=0: fire_pulse=1 for one cycle, and shots increments unless it is already 255.
  - On fire_rise otherwise: fire_reject=1 for one cycle.
  - Button release produces nothing. Holding the button produces exactly one pulse.
- Row, column and the flags are not cleared by firing; the player may re-fire at the same target.

## Timing
- Reset (reset=0, async) forces the following to 0: all synchronizer flops, stable registers, debounce counters, row, column, row_ok, col_ok, target_valid, sel_error, fire_pulse, fire_reject and shots.
- Release of reset is synchronized by the surrounding design.
- Latency from raw change to stable update is 2 sync cycles plus DEBOUNCE_CYCLES cycles.
- sel_error, row and column update 1 cycle after the debounced switch change.
- fire_pulse or fire_reject is registered and asserts 1 cycle after the stable fire rising edge.
- Simultaneous events: fire qualification uses the registered row, column, target_valid and sel_error values from the same cycle. A latch update in that cycle affects only later fires.
- Reset mid-debounce discards the partial count. Reset in the pulse cycle clears the pulse immediately.
- If the button is held through reset release, the debounced fire rises later. It produces fire_reject, because target_valid=0.
- fire_pulse and fire_reject are mutually exclusive and never assert in consecutive cycles; a minimum of DEBOUNCE_CYCLES separates them.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold reset=0 with random raw inputs for 10 cycles → all outputs 0; deassert and keep inputs 0 → outputs remain 0.
- Bounce rejection: fire_btn toggles every 2 cycles for 20 cycles, then held at 1 with row=0010 and column=0100 latched → exactly one fire_pulse, arriving 7 cycles after the final rise; shots=1.
- Selection: n_row=0 and sw=0100 → row=0100 after debounce. Then n_row=1 and sw=0001 → column=0001, target_valid=1. Then sw=0000 → row and column unchanged.
- Error: sw=0110 → sel_error=1 and row/column unchanged. A press in this state → fire_reject=1, fire_pulse=0, shots unchanged.
- Fire without target: after reset, latch only the row, then press → fire_reject for one cycle. Latch the column, press again → fire_pulse for one cycle.
- Saturation: with a valid target, 260 clean presses → shots=255 with 260 fire_pulses; reset mid-count → shots=0 immediately.
